// File: rtl/serial_receiver_if.sv
// Byte-side handshake bundle of the UART receiver: received byte, REQ/ACK pair
// and the two status flags. The receiver is the master, the consumer the slave.
interface serial_receiver_if;
    logic [7:0] RCV_DATA;
    logic       RCV_REQ;
    logic       RCV_ACK;
    logic       FRAME_ERR;
    logic       OVERRUN;

    modport master (
        output RCV_DATA,
        output RCV_REQ,
        output FRAME_ERR,
        output OVERRUN,
        input  RCV_ACK
    );

    modport slave (
        input  RCV_DATA,
        input  RCV_REQ,
        input  FRAME_ERR,
        input  OVERRUN,
        output RCV_ACK
    );
endinterface

// File: rtl/serial_receiver.sv
// 8N1 serial receiver. RCV is synchronised through two flops, deserialised by
// the receive FSM, and each good byte is offered to the consumer through a
// four-phase REQ/ACK handshake FSM. A stop bit sampled low pulses FRAME_ERR;
// a byte completing while the previous one is still owned sets sticky OVERRUN.
module serial_receiver #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              RCV,
    serial_receiver_if.master rcv
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    // IDLE spends one cycle registering the falling edge and START begins
    // counting from zero, so the mid-start sample lands two counts early.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_RECOVER
    } rx_state_e;

    typedef enum logic [1:0] {
        HS_EMPTY,
        HS_FULL,
        HS_DRAIN
    } hs_state_e;

    // Synchroniser
    logic [1:0] sync_q, sync_d;
    logic       rx_s;

    // Receive FSM and datapath
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;

    // Receive FSM strobes
    logic sample_now;
    logic byte_ok;
    logic byte_bad;

    // Handshake FSM
    hs_state_e hs_state_q, hs_state_d;
    logic      load_byte;
    logic      overrun_evt;

    // Output registers
    logic [7:0] data_q, data_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    assign rx_s = sync_q[1];

    // Synchroniser next value: shift RCV in from the bottom.
    always_comb begin
        sync_d = {sync_q[0], RCV};
    end

    // Synchroniser flops; reset to the idle-line level.
    always_ff @(posedge clk) begin
        if (!clr) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Receive FSM state register plus bit-period counter, bit index and shifter.
    always_ff @(posedge clk) begin
        if (!clr) begin
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // Receive FSM next-state and datapath updates.
    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        unique case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (!rx_s) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (sample_now) begin
                    clk_cnt_d  = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (sample_now) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (sample_now) begin
                    clk_cnt_d  = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_RECOVER;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_RECOVER: begin
                clk_cnt_d = '0;
                if (rx_s) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                clk_cnt_d  = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // Receive FSM outputs: sampling strobe and stop-bit outcome.
    always_comb begin
        sample_now = 1'b0;
        unique case (rx_state_q)
            RX_START:         sample_now = (clk_cnt_q == HALF_LAST);
            RX_DATA, RX_STOP: sample_now = (clk_cnt_q == BIT_LAST);
            default:          sample_now = 1'b0;
        endcase
        byte_ok  = (rx_state_q == RX_STOP) && sample_now && rx_s;
        byte_bad = (rx_state_q == RX_STOP) && sample_now && !rx_s;
    end

    // Handshake FSM state register.
    always_ff @(posedge clk) begin
        if (!clr) begin
            hs_state_q <= HS_EMPTY;
        end else begin
            hs_state_q <= hs_state_d;
        end
    end

    // Handshake FSM next state: EMPTY -> FULL -> (ACK) DRAIN -> (!ACK) EMPTY.
    always_comb begin
        hs_state_d = hs_state_q;
        unique case (hs_state_q)
            HS_EMPTY: if (byte_ok)       hs_state_d = HS_FULL;
            HS_FULL:  if (rcv.RCV_ACK)   hs_state_d = HS_DRAIN;
            HS_DRAIN: if (!rcv.RCV_ACK)  hs_state_d = HS_EMPTY;
            default:                     hs_state_d = HS_EMPTY;
        endcase
    end

    // Handshake FSM outputs: REQ, byte load, and overrun when the slot is owned.
    always_comb begin
        rcv.RCV_REQ = (hs_state_q == HS_FULL);
        load_byte   = byte_ok && (hs_state_q == HS_EMPTY);
        overrun_evt = byte_ok && (hs_state_q != HS_EMPTY);
    end

    // Output register next values.
    always_comb begin
        data_d      = load_byte ? shift_q : data_q;
        frame_err_d = byte_bad;
        overrun_d   = overrun_q | overrun_evt;
    end

    // Output registers: held byte, framing-error pulse, sticky overrun.
    always_ff @(posedge clk) begin
        if (!clr) begin
            data_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Drive the interface from the output registers.
    always_comb begin
        rcv.RCV_DATA  = data_q;
        rcv.FRAME_ERR = frame_err_q;
        rcv.OVERRUN   = overrun_q;
    end

endmodule

// File: doc/serial_receiver.md
# serial_receiver

Serial-to-parallel receiver for the board's UART link: it deserialises 8N1 frames arriving on `RCV` and presents each byte to the consuming logic over a four-phase `RCV_REQ`/`RCV_ACK` handshake. This is the same REQ/ACK style that the transmit side accepts from its producer. It sits between the input pin and the command/data consumer, and flags framing errors and overruns.

## Interface
- `CLKS_PER_BIT`, default 10: clk cycles per bit period. Must be even and ≥ 4.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `clr`  in  1  synchronous, active-low reset.
- `RCV`  in  1  serial line, asynchronous. Idles high.
- `RCV_DATA`  out  8  received byte. Stable while `RCV_REQ`=1.
- `RCV_REQ`  out  1  byte available.
- `RCV_ACK`  in  1  consumer acknowledge.
- `FRAME_ERR`  out  1  one-cycle pulse: stop bit was sampled low.
- `OVERRUN`  out  1  sticky. A frame completed while `RCV_REQ`=1. Cleared only by reset.

## Operation
- **Input synchroniser:** `RCV` passes through 2 flops (reset value 1) to give `rx_s`.
- **Frame format:** start bit (0), D0..D7 LSB first, stop bit (1).
- **Receive FSM:** IDLE, START, DATA, STOP, RECOVER.
  - **IDLE:** waits for `rx_s`=0, then clears the bit counter and goes to START.
  - **START:** waits `CLKS_PER_BIT/2` cycles, then samples `rx_s`.
    - If 0, goes to DATA with bit index 0.
    - If 1 (glitch), goes back to IDLE with no output activity.
  - **DATA:** samples `rx_s` every `CLKS_PER_BIT` cycles and shifts it into the MSB of the shift register (right shift). After the 8th sample, goes to STOP.
  - **STOP:** samples `rx_s` after `CLKS_PER_BIT` cycles.
    - **Sample = 1:** the byte is complete and the FSM returns to IDLE.
      - If `RCV_REQ`=0, load `RCV_DATA` and set `RCV_REQ`.
      - If `RCV_REQ`=1, discard the byte, set `OVERRUN`, and leave `RCV_DATA` unchanged.
    - **Sample = 0:** pulse `FRAME_ERR` and discard the byte. Go to RECOVER.
  - **RECOVER:** waits for `rx_s`=1, then goes to IDLE.
- **Handshake FSM:** EMPTY, FULL, DRAIN.
  - EMPTY → FULL on byte completion. `RCV_REQ`=1 in FULL.
  - FULL → DRAIN on `RCV_ACK`=1. `RCV_REQ` drops the cycle after ACK is seen.
  - DRAIN → EMPTY on `RCV_ACK`=0. A new REQ cannot rise before ACK falls.
  - A byte completing while in DRAIN counts as an overrun (`RCV_REQ` is treated as still owned).
- The receive FSM runs independently of the handshake FSM. Reception continues while a byte is pending.
- **Reset** (`clr`=0 at a clk edge), including mid-frame:
  - Both FSMs go to IDLE/EMPTY.
  - `RCV_REQ`=0, `RCV_DATA`=8'h00, `FRAME_ERR`=0, `OVERRUN`=0.
  - Synchroniser flops go to 1 and all counters to 0.
  - A partial frame is discarded.
  - After release, the first falling edge is treated as a start bit.

## Timing
- Let E be the first clk edge at which the synchroniser captures `RCV`=0 (the start edge). `rx_s` goes low at E+1.
- Start sample at E+1+`CLKS_PER_BIT/2`. Data bit k is sampled at E+1+`CLKS_PER_BIT/2`+(k+1)·`CLKS_PER_BIT`.
- Stop sample at E+1+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`. `RCV_REQ`, `RCV_DATA` and `FRAME_ERR` update at that edge.
  - With default 10, this is E+96.
- IDLE accepts a new start edge on the cycle after the stop sample. Back-to-back frames therefore need no gap beyond the stop bit.
- `RCV_REQ` falls on the first edge where `RCV_ACK`=1 is registered in FULL. Minimum REQ high time is 1 cycle.
- Bit-period counter width is `$clog2(CLKS_PER_BIT)` bits and wraps to 0 at `CLKS_PER_BIT`-1.

## Test plan
- **Single frame:** reset, then drive 0xA5 at 10 clk/bit with `RCV_ACK` tied to `RCV_REQ`.
  - `RCV_DATA`=8'hA5 with `RCV_REQ`=1 at E+96.
  - REQ falls 1 cycle after ACK. `FRAME_ERR`=0, `OVERRUN`=0.
- **Back-to-back:** frames 0x00, 0xFF, 0x3C with no idle gap, consumer acking within 20 cycles.
  - Three REQ/ACK handshakes with the correct bytes. No flags.
- **False start:** `RCV` low for 3 cycles, then high.
  - No `RCV_REQ`, no `FRAME_ERR`. FSM back in IDLE.
  - A following 0x5A frame is received correctly.
- **Framing error:** 0x81 frame with the stop bit driven 0 and the line then held low 30 cycles.
  - One-cycle `FRAME_ERR` at E+96, no REQ.
  - The next valid frame is received only after the line returns high.
- **Overrun:** send 0x11 with ACK withheld, then send 0x22.
  - `RCV_DATA` stays 0x11. `OVERRUN` rises at the second stop sample and stays 1 after ACK.
- **Reset mid-frame:** assert `clr`=0 for 1 cycle during D4 of 0xC3.
  - All outputs at reset values, no REQ.
  - A following 0x7E frame yields `RCV_DATA`=8'h7E.
